// File: rtl/downscale_scheduler.sv
// Downscale job scheduler: output dimensions by repeated subtraction, then raster-order SIMD job issue.
// Optional macro DS_PERF_CNT_EN adds the o_cyc_cnt / o_stall_cnt performance counters.
module downscale_scheduler #(
    parameter int MAX_LANES       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DIM_W           = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIM_W-1:0]     img_width,
    input  logic [DIM_W-1:0]     img_height,
    input  logic [2:0]           N_simd,
    input  logic [7:0]           scale_factor,
    output logic                 o_job_valid,
    input  logic                 i_job_ready,
    output logic [DIM_W-1:0]     o_src_x,
    output logic [DIM_W-1:0]     o_src_y,
    output logic [DIM_W-1:0]     o_dst_x,
    output logic [DIM_W-1:0]     o_dst_y,
    output logic [MAX_LANES-1:0] o_lane_mask,
    input  logic                 i_job_done,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [DIM_W-1:0]     o_out_width,
`ifdef DS_PERF_CNT_EN
    output logic [DIM_W-1:0]     o_out_height,
    output logic [31:0]          o_cyc_cnt,
    output logic [31:0]          o_stall_cnt
`else
    output logic [DIM_W-1:0]     o_out_height
`endif
);

    localparam int LW = $clog2(MAX_LANES + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, DONE, ERR} state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] scale_in, scale_q;
    logic [DIM_W-1:0] rem_w, rem_h, cnt_w, cnt_h;
    logic [DIM_W-1:0] lane_step;
    logic [LW-1:0]    lanes_in, lanes_q;
    logic [OW-1:0]    outstanding;
    logic [DIM_W:0]   x_plus_lanes;
    logic             cfg_err, init_exit, accept, row_end, last_row, done_take;

    function automatic logic [MAX_LANES-1:0] lane_mask_f(input logic [DIM_W-1:0] x,
                                                         input logic [DIM_W-1:0] w,
                                                         input logic [LW-1:0]    n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++)
            m[i] = (({1'b0, x} + (DIM_W+1)'(i)) < {1'b0, w}) && (i < int'(n));
        return m;
    endfunction

    assign scale_in = DIM_W'(scale_factor);
    assign cfg_err  = (scale_factor == '0) || (scale_in > img_width) || (scale_in > img_height);

    always_comb begin
        if (N_simd == '0)
            lanes_in = LW'(1);
        else if (int'(N_simd) > MAX_LANES)
            lanes_in = LW'(MAX_LANES);
        else
            lanes_in = LW'(N_simd);
    end

    // lanes*scale as a short chain of conditional adds; lanes never exceeds MAX_LANES.
    always_comb begin
        lane_step = '0;
        for (int i = 0; i < MAX_LANES; i++)
            if (i < int'(lanes_q)) lane_step = lane_step + scale_q;
    end

    assign x_plus_lanes = {1'b0, o_dst_x} + (DIM_W+1)'(lanes_q);
    assign row_end      = x_plus_lanes >= {1'b0, o_out_width};
    assign last_row     = o_dst_y == (o_out_height - DIM_W'(1));
    assign init_exit    = (rem_w < scale_q) && (rem_h < scale_q);
    assign accept       = o_job_valid && i_job_ready;
    assign done_take    = i_job_done && (outstanding != '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        o_job_valid = 1'b0;
        o_busy      = (state_q != IDLE);
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = cfg_err ? ERR : INIT;
            INIT:  if (init_exit) state_d = ISSUE;
            ISSUE: begin
                o_job_valid = (outstanding < OW'(MAX_OUTSTANDING));
                if (o_job_valid && i_job_ready && row_end && last_row) state_d = DRAIN;
            end
            DRAIN: if (outstanding == '0) state_d = DONE;
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                o_err   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            scale_q      <= '0;
            lanes_q      <= '0;
            rem_w        <= '0;
            rem_h        <= '0;
            cnt_w        <= '0;
            cnt_h        <= '0;
            outstanding  <= '0;
            o_src_x      <= '0;
            o_src_y      <= '0;
            o_dst_x      <= '0;
            o_dst_y      <= '0;
            o_lane_mask  <= '0;
            o_out_width  <= '0;
            o_out_height <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    scale_q <= scale_in;
                    lanes_q <= lanes_in;
                    rem_w   <= img_width;
                    rem_h   <= img_height;
                    cnt_w   <= '0;
                    cnt_h   <= '0;
                end
                INIT: begin
                    if (rem_w >= scale_q) begin
                        rem_w <= rem_w - scale_q;
                        cnt_w <= cnt_w + DIM_W'(1);
                    end
                    if (rem_h >= scale_q) begin
                        rem_h <= rem_h - scale_q;
                        cnt_h <= cnt_h + DIM_W'(1);
                    end
                    if (init_exit) begin
                        o_out_width  <= cnt_w;
                        o_out_height <= cnt_h;
                        o_dst_x      <= '0;
                        o_dst_y      <= '0;
                        o_src_x      <= '0;
                        o_src_y      <= '0;
                        o_lane_mask  <= lane_mask_f('0, cnt_w, lanes_q);
                    end
                end
                ISSUE: if (accept) begin
                    if (row_end) begin
                        o_dst_x     <= '0;
                        o_src_x     <= '0;
                        o_dst_y     <= o_dst_y + DIM_W'(1);
                        o_src_y     <= o_src_y + scale_q;
                        o_lane_mask <= lane_mask_f('0, o_out_width, lanes_q);
                    end else begin
                        o_dst_x     <= x_plus_lanes[DIM_W-1:0];
                        o_src_x     <= o_src_x + lane_step;
                        o_lane_mask <= lane_mask_f(x_plus_lanes[DIM_W-1:0], o_out_width, lanes_q);
                    end
                end
                default: ;
            endcase
            // An accept and a completion in the same cycle cancel out.
            if (accept && !done_take)
                outstanding <= outstanding + OW'(1);
            else if (!accept && done_take)
                outstanding <= outstanding - OW'(1);
        end
    end

`ifdef DS_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && start)) begin
            o_cyc_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (o_busy) o_cyc_cnt <= o_cyc_cnt + 32'd1;
            if (o_job_valid && !i_job_ready) o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_downscale_scheduler.sv
// Directed self-checking bench for downscale_scheduler: job grid, error configs, backpressure, reset abort.
module tb_downscale_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] img_width, img_height;
    logic [2:0] N_simd;
    logic [7:0] scale_factor;
    logic       o_job_valid, i_job_ready, i_job_done;
    logic [8:0] o_src_x, o_src_y, o_dst_x, o_dst_y;
    logic [3:0] o_lane_mask;
    logic       o_busy, o_done, o_err;
    logic [8:0] o_out_width, o_out_height;

    downscale_scheduler dut (
        .clk(clk), .reset(reset), .start(start),
        .img_width(img_width), .img_height(img_height),
        .N_simd(N_simd), .scale_factor(scale_factor),
        .o_job_valid(o_job_valid), .i_job_ready(i_job_ready),
        .o_src_x(o_src_x), .o_src_y(o_src_y), .o_dst_x(o_dst_x), .o_dst_y(o_dst_y),
        .o_lane_mask(o_lane_mask), .i_job_done(i_job_done),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_out_width(o_out_width), .o_out_height(o_out_height)
    );

    always #5 clk = ~clk;

    logic [61:0] all_outs;
    assign all_outs = {o_job_valid, o_src_x, o_src_y, o_dst_x, o_dst_y, o_lane_mask,
                       o_busy, o_done, o_err, o_out_width, o_out_height};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt, err_cnt, busy_cyc;
    int ready_mode = 0;   // 0: ready high, 1: random, 2: ready low
    int done_dly = 2;     // negative: completions withheld
    int done_at [0:19999];
    logic [39:0] jobs [$];
    logic [39:0] prev_fields;
    bit stalled_prev = 1'b0;
    int n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pack(input int sx, input int sy, input int dx, input int dy, input int m);
        return {9'(sx), 9'(sy), 9'(dx), 9'(dy), 4'(m)};
    endfunction

    // One cycle: observe at negedge, then drive ready/done for the next edge and log accepted jobs.
    task tick();
        logic [39:0] cur;
        bit rdy;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        cur = {o_src_x, o_src_y, o_dst_x, o_dst_y, o_lane_mask};
        if (o_done === 1'b1) done_cnt++;
        if (o_err === 1'b1) err_cnt++;
        if (o_busy === 1'b1) busy_cyc++;
        if (stalled_prev) check("stall_hold", {o_job_valid, cur}, {1'b1, prev_fields});
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
        endcase
        i_job_ready = rdy;
        i_job_done  = done_at[cyc] > 0;
        if (done_at[cyc] > 1) done_at[cyc+1] += done_at[cyc] - 1;
        if (o_job_valid === 1'b1 && rdy) begin
            jobs.push_back(cur);
            if (done_dly >= 0) done_at[cyc+done_dly] += 1;
        end
        stalled_prev = (o_job_valid === 1'b1) && !rdy;
        prev_fields  = cur;
    endtask

    task automatic start_run(input int w, input int h, input int lanes, input int s);
        img_width    = 9'(w);
        img_height   = 9'(h);
        N_simd       = 3'(lanes);
        scale_factor = 8'(s);
        start        = 1'b1;
    endtask

    task automatic clr();
        done_cnt = 0;
        err_cnt  = 0;
        busy_cyc = 0;
        jobs.delete();
    endtask

    task automatic run_to_end(input int max_cyc);
        int k = 0;
        int ev0 = done_cnt + err_cnt;
        while ((done_cnt + err_cnt) == ev0 && k < max_cyc) begin
            tick();
            k++;
        end
        check("end_within_budget", k < max_cyc, 1'b1);
        tick();
        check("busy_drops", o_busy, 1'b0);
    endtask

    task automatic check_grid(input string tag, input int ow, input int oh, input int ln, input int sc);
        int jpr, bad, dx, dy;
        logic [3:0] m;
        jpr = (ow + ln - 1) / ln;
        bad = 0;
        check({tag, "_job_count"}, jobs.size(), oh * jpr);
        foreach (jobs[k]) begin
            dx = (k % jpr) * ln;
            dy = k / jpr;
            m  = '0;
            for (int i = 0; i < 4; i++) m[i] = (dx + i < ow) && (i < ln);
            if (jobs[k] !== pack(dx * sc, dy * sc, dx, dy, m)) bad++;
        end
        check({tag, "_bad_jobs"}, bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        i_job_ready = 1'b0;
        i_job_done = 1'b0;
        img_width = '0;
        img_height = '0;
        N_simd = '0;
        scale_factor = '0;
        for (int i = 0; i < 20000; i++) done_at[i] = 0;
        clr();

        // Reset state
        tick();
        tick();
        check("reset_outputs", all_outs, 62'd0);
        reset = 1'b0;
        tick();

        // 64x32 / 3 with 2 lanes: 21x10 output, 11 jobs per row
        clr();
        start_run(64, 32, 2, 3);
        run_to_end(2000);
        check("t1_out_width", o_out_width, 21);
        check("t1_out_height", o_out_height, 10);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_no_err", err_cnt, 0);
        check("t1_row0_tail", jobs[10], pack(60, 0, 20, 0, 1));
        check("t1_row1_job2", jobs[13], pack(12, 3, 4, 1, 3));
        check("t1_last_job", jobs[109], pack(60, 27, 20, 9, 1));
        check_grid("t1", 21, 10, 2, 3);

        // Invalid configurations: scale 0, then scale wider than the image
        clr();
        tick();
        start_run(64, 32, 2, 0);
        run_to_end(20);
        check("t2a_err_pulses", err_cnt, 1);
        check("t2a_no_done", done_cnt, 0);
        check("t2a_no_jobs", jobs.size(), 0);
        check("t2a_busy_le2", busy_cyc <= 2, 1'b1);
        clr();
        tick();
        start_run(64, 64, 2, 65);
        run_to_end(20);
        check("t2b_err_pulses", err_cnt, 1);
        check("t2b_no_done", done_cnt, 0);
        check("t2b_no_jobs", jobs.size(), 0);
        check("t2b_busy_le2", busy_cyc <= 2, 1'b1);

        // Stray completion while idle must not underflow the in-flight count
        tick();
        i_job_done = 1'b1;
        tick();

        // 3x3 / 1 with 7 lanes requested, clamped to 4
        clr();
        tick();
        start_run(3, 3, 7, 1);
        run_to_end(200);
        check("t3_job0", jobs[0], pack(0, 0, 0, 0, 7));
        check("t3_job1", jobs[1], pack(0, 1, 0, 1, 7));
        check("t3_job2", jobs[2], pack(0, 2, 0, 2, 7));
        check("t3_done_pulses", done_cnt, 1);
        check_grid("t3", 3, 3, 4, 1);

        // 8x8 / 2 with 1 lane, completions withheld: in-flight cap, then released one at a time
        clr();
        done_dly = -1;
        tick();
        start_run(8, 8, 1, 2);
        repeat (30) tick();
        check("t4_capped_jobs", jobs.size(), 4);
        check("t4_valid_low_at_cap", o_job_valid, 1'b0);
        for (int r = 0; r < 3; r++) begin
            n = jobs.size();
            i_job_done = 1'b1;
            repeat (6) tick();
            check("t4_one_release", jobs.size(), n + 1);
            check("t4_valid_low_again", o_job_valid, 1'b0);
        end
        done_at[cyc+1] += 4;
        done_dly   = 2;
        ready_mode = 1;
        run_to_end(2000);
        check("t4_done_pulses", done_cnt, 1);
        check_grid("t4", 4, 4, 1, 2);
        ready_mode = 0;

        // Reset in the middle of ISSUE
        clr();
        tick();
        start_run(64, 32, 2, 3);
        n = 0;
        while (jobs.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        check("t5_reached_issue", jobs.size() >= 5, 1'b1);
        ready_mode = 2;
        tick();
        reset = 1'b1;
        stalled_prev = 1'b0;
        for (int i = 0; i < 20000; i++) done_at[i] = 0;
        tick();
        reset = 1'b0;
        check("t5_reset_outputs", all_outs, 62'd0);
        ready_mode = 0;
        repeat (8) tick();
        check("t5_no_done_after_abort", done_cnt, 0);
        check("t5_idle_after_abort", o_busy, 1'b0);
        clr();
        tick();
        start_run(64, 32, 2, 3);
        run_to_end(2000);
        check("t5_out_width", o_out_width, 21);
        check("t5_out_height", o_out_height, 10);
        check("t5_done_pulses", done_cnt, 1);
        check_grid("t5", 21, 10, 2, 3);

        // Second start during ISSUE is ignored
        clr();
        tick();
        start_run(64, 32, 2, 3);
        n = 0;
        while (jobs.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        start_run(16, 16, 1, 1);
        run_to_end(2000);
        check("t6_out_width", o_out_width, 21);
        check("t6_out_height", o_out_height, 10);
        check("t6_done_pulses", done_cnt, 1);
        check_grid("t6", 21, 10, 2, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
